// File: rtl/sr_pulse_gen_if.sv
// sr_pulse_gen_if
// Groups the push-button inputs and latch-drive outputs of sr_pulse_gen.
//   set_btn  : raw asynchronous set button, active-high
//   clr_btn  : raw asynchronous clear button, active-high
//   s        : active-low set to the NAND SR latch, idle 1
//   r        : active-low reset to the NAND SR latch, idle 1
//   busy     : high while a pulse is being driven
//   conflict : one-cycle strobe when both debounced buttons rise together
// master drives the buttons (button source / bench); slave is the pulse generator.
interface sr_pulse_gen_if;
    logic set_btn;
    logic clr_btn;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_btn,
        output clr_btn,
        input  s,
        input  r,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_btn,
        input  clr_btn,
        output s,
        output r,
        output busy,
        output conflict
    );
endinterface

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen
// Front end for a NAND SR latch. Two raw buttons are synchronized and
// debounced; a clean press of exactly one button produces a fixed-width
// active-low pulse on s (set) or r (clear). Simultaneous presses are
// reported on conflict instead of being driven, so s=0,r=0 never occurs.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : sr_pulse_gen_if.slave (set_btn, clr_btn in; s, r, busy, conflict out)
// Parameters:
//   DEBOUNCE_CYCLES : cycles a new level must persist before it is accepted (1..255)
//   PULSE_CYCLES    : width of each active-low pulse in cycles (1..255)
module sr_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic           clk,
    input  logic           rst,
    sr_pulse_gen_if.slave  bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PC_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    // Bit 0 carries the set button, bit 1 the clear button.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_sync_q;
    logic [1:0]      r_stable;
    logic [1:0]      r_stable_d;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      w_press;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pcnt;
    logic [PC_W-1:0] w_pcnt_nxt;
    logic            r_s;
    logic            r_r;
    logic            r_busy;
    logic            r_conflict;
    logic            w_conflict_nxt;

    // Input path: two synchronizer flops, then a registered copy that the
    // debouncer judges, so the accepted level appears 2+DEBOUNCE_CYCLES
    // edges after the button is first sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync_q   <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= {bus.clr_btn, bus.set_btn};
            r_sync2    <= r_sync1;
            r_sync_q   <= r_sync2;
            r_stable_d <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (r_sync_q[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    // The mismatch that would complete the run flips the level instead.
                    r_stable[i] <= ~r_stable[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only rising debounced edges count; releases are ignored.
    assign w_press = r_stable & ~r_stable_d;

    // FSM / pulse counter next-state and registered-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_pcnt_nxt     = r_pcnt;
        w_conflict_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[0] && w_press[1]) begin
                    w_conflict_nxt = 1'b1;
                end else if (w_press[0]) begin
                    w_state_nxt = ST_SET;
                    w_pcnt_nxt  = PC_LOAD;
                end else if (w_press[1]) begin
                    w_state_nxt = ST_CLR;
                    w_pcnt_nxt  = PC_LOAD;
                end
            end
            ST_SET, ST_CLR: begin
                // Presses seen here are dropped, never queued.
                if (r_pcnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pcnt_nxt = r_pcnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pcnt_nxt  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so s and r
    // can only be low in mutually exclusive states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pcnt     <= '0;
            r_s        <= 1'b1;
            r_r        <= 1'b1;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_s        <= (w_state_nxt != ST_SET);
            r_r        <= (w_state_nxt != ST_CLR);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_conflict <= w_conflict_nxt;
        end
    end

    assign bus.s        = r_s;
    assign bus.r        = r_r;
    assign bus.busy     = r_busy;
    assign bus.conflict = r_conflict;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Self-checking bench for sr_pulse_gen with a scoreboard of output events.
module tb_sr_pulse_gen;

    localparam int D    = 4;
    localparam int P    = 2;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst;

    sr_pulse_gen_if bus ();

    sr_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_SET, EV_CLR, EV_END, EV_CONF} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       at;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = -1;   // index of the most recent rising edge

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", name, cyc, act, req);
        end
    endtask

    task automatic sb_pop(string name, ev_kind_t k);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: DUT showed %s at edge %0d, none expected", name, k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                bad++;
                $display("FAIL %s: got %s at edge %0d, want %s at edge %0d",
                         name, k.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Event-level model: a button level is accepted once D consecutive
    // judged samples disagree with the current level; an accepted rise is a
    // press; a press starts a P-cycle pulse only when no pulse is running.
    bit rst_h [MAXC];
    bit btn_h [2][MAXC];
    bit smp_h [2][MAXC];
    bit stab_h[2][MAXC];
    int last_tog[2];
    bit m_press[2];
    bit m_prev;
    bit m_flip;
    bit m_busy = 1'b0;
    int m_end  = 0;
    int m_t;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            m_t          = cyc;
            rst_h[m_t]   = rst;
            btn_h[0][m_t] = bus.set_btn;
            btn_h[1][m_t] = bus.clr_btn;
            for (int b = 0; b < 2; b++) begin
                // Judged level: the button as it was three edges back, read
                // as low while a reset within those three edges flushes it.
                if (m_t < 3 || rst_h[m_t-1] || rst_h[m_t-2] || rst_h[m_t-3])
                    smp_h[b][m_t] = 1'b0;
                else
                    smp_h[b][m_t] = btn_h[b][m_t-3];
                if (rst_h[m_t] || m_t == 0) begin
                    stab_h[b][m_t] = 1'b0;
                    last_tog[b]    = m_t;
                end else begin
                    m_prev = stab_h[b][m_t-1];
                    m_flip = (last_tog[b] <= m_t - D);
                    if (m_flip) begin
                        for (int k = 0; k < D; k++)
                            if (smp_h[b][m_t-k] == m_prev) m_flip = 1'b0;
                    end
                    stab_h[b][m_t] = m_flip ? ~m_prev : m_prev;
                    if (m_flip) last_tog[b] = m_t;
                end
                m_press[b] = (m_t >= 2) && stab_h[b][m_t-1] &&
                             !(rst_h[m_t-1] ? 1'b0 : stab_h[b][m_t-2]);
            end
            if (rst_h[m_t]) begin
                if (m_busy) exp_q.push_back('{kind: EV_END, at: m_t});
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_t == m_end) begin
                    exp_q.push_back('{kind: EV_END, at: m_t});
                    m_busy = 1'b0;
                end
            end else if (m_press[0] && m_press[1]) begin
                exp_q.push_back('{kind: EV_CONF, at: m_t});
            end else if (m_press[0] || m_press[1]) begin
                exp_q.push_back('{kind: (m_press[0] ? EV_SET : EV_CLR), at: m_t});
                m_busy = 1'b1;
                m_end  = m_t + P;
            end
        end
    end

    // ---------------- monitor ----------------
    bit       prev_busy = 1'b0;
    ev_kind_t cur_kind  = EV_SET;

    always @(negedge clk) begin
        if (cyc >= 0) begin
            check("no_s0_r0", int'(bus.s === 1'b0 && bus.r === 1'b0), 0);
            if (bus.busy === 1'b1 && !prev_busy) begin
                cur_kind = (bus.s === 1'b0) ? EV_SET : EV_CLR;
                sb_pop("pulse_start", cur_kind);
            end else if (bus.busy !== 1'b1 && prev_busy) begin
                sb_pop("pulse_end", EV_END);
            end
            if (bus.conflict === 1'b1) sb_pop("conflict", EV_CONF);
            if (bus.busy === 1'b1) begin
                check("s_during_pulse", int'(bus.s), (cur_kind == EV_SET) ? 0 : 1);
                check("r_during_pulse", int'(bus.r), (cur_kind == EV_CLR) ? 0 : 1);
            end else begin
                check("s_idle", int'(bus.s), 1);
                check("r_idle", int'(bus.r), 1);
            end
            prev_busy = (bus.busy === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic press_check(bit use_set);
        int e0;
        if (use_set) bus.set_btn = 1'b1; else bus.clr_btn = 1'b1;
        e0 = cyc + 1;
        wait_to(e0 + 2 + D);
        check("busy_before_latency", int'(bus.busy), 0);
        wait_to(e0 + 3 + D);
        check("busy_at_latency", int'(bus.busy), 1);
        check(use_set ? "s_low_at_latency" : "r_low_at_latency",
              int'(use_set ? bus.s : bus.r), 0);
        wait_to(e0 + 2 + D + P);
        check("busy_last_pulse_cycle", int'(bus.busy), 1);
        wait_to(e0 + 3 + D + P);
        check("busy_after_pulse", int'(bus.busy), 0);
        check("s_after_pulse", int'(bus.s), 1);
        check("r_after_pulse", int'(bus.r), 1);
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        tick(D + 8);
    endtask

    initial begin
        int e0;
        rst         = 1'b1;
        bus.set_btn = 1'b1;
        bus.clr_btn = 1'b1;
        @(negedge clk);
        check("reset_s", int'(bus.s), 1);
        check("reset_r", int'(bus.r), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_conflict", int'(bus.conflict), 0);
        tick(2);
        // set still held when reset drops: counts as a fresh press
        rst         = 1'b0;
        bus.clr_btn = 1'b0;
        e0 = cyc + 1;
        wait_to(e0 + 2 + D);
        check("post_reset_idle", int'(bus.busy), 0);
        wait_to(e0 + 3 + D);
        check("post_reset_set_pulse", int'(bus.s), 0);
        bus.set_btn = 1'b0;
        tick(D + 10);

        press_check(1'b1);
        press_check(1'b0);

        // bounce: 3 high, 1 low, 2 high, then a clean 10-cycle hold
        bus.set_btn = 1'b1; tick(3);
        bus.set_btn = 1'b0; tick(1);
        bus.set_btn = 1'b1; tick(2);
        bus.set_btn = 1'b0; tick(10);
        check("bounce_no_pulse", int'(bus.busy), 0);
        bus.set_btn = 1'b1; tick(10);
        bus.set_btn = 1'b0; tick(12);

        // simultaneous presses
        bus.set_btn = 1'b1;
        bus.clr_btn = 1'b1;
        e0 = cyc + 1;
        wait_to(e0 + 3 + D);
        check("conflict_strobe", int'(bus.conflict), 1);
        check("conflict_busy", int'(bus.busy), 0);
        wait_to(e0 + 4 + D);
        check("conflict_one_cycle", int'(bus.conflict), 0);
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        tick(12);

        // clear pressed one cycle after set: dropped, then re-pressed later
        bus.set_btn = 1'b1; tick(1);
        bus.clr_btn = 1'b1; tick(12);
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0; tick(12);
        press_check(1'b0);

        // reset in the middle of a set pulse
        bus.set_btn = 1'b1;
        e0 = cyc + 1;
        wait_to(e0 + 3 + D);
        rst = 1'b1;
        wait_to(e0 + 4 + D);
        check("midpulse_reset_s", int'(bus.s), 1);
        check("midpulse_reset_busy", int'(bus.busy), 0);
        rst         = 1'b0;
        bus.set_btn = 1'b0;
        tick(15);

        // randomized buttons with occasional reset
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) bus.set_btn = ~bus.set_btn;
            if ($urandom_range(0, 5) == 0) bus.clr_btn = ~bus.clr_btn;
            rst = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst         = 1'b0;
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        tick(40);

        check("events_outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
